button_gesture: RTL and testbench
=================================

# button_gesture

Classifies debounced push-button activity into gesture events: short press, double press, long press, and auto-repeat while held. It sits directly downstream of the button debouncer, consuming its debounced level and one-cycle press pulse. It drives one-cycle event strobes to the lab's control logic, which are suitable for mode stepping and value increment/decrement.

## Interface
- CLKFREQ, 100_000_000: clock frequency in Hz.
- LONG_PRESS_MS, 500: hold time that qualifies a long press.
- DOUBLE_GAP_MS, 250: maximum release-to-second-press gap for a double press.
- REPEAT_MS, 100: auto-repeat period after a long press.
- Derived localparams:
  - LONG_COUNT = LONG_PRESS_MS*(CLKFREQ/1000)
  - GAP_COUNT = DOUBLE_GAP_MS*(CLKFREQ/1000)
  - REPEAT_COUNT = REPEAT_MS*(CLKFREQ/1000)
  - Each derived count must be ≥ 2.
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- btn_level  input  1  debounced button level (1 = pressed).
- btn_press  input  1  one-cycle strobe on debounced 0→1.
- short_press  output  1  one-cycle strobe: single press released, no second press within the gap.
- double_press  output  1  one-cycle strobe: second press within the gap.
- long_press  output  1  one-cycle strobe: button held for LONG_COUNT cycles.
- repeat_tick  output  1  one-cycle strobe every REPEAT_COUNT cycles while held after long_press.
- busy  output  1  high whenever state ≠ IDLE.

## Operation
- State machine: IDLE, PRESS1, GAP, PRESS2, HELD. A 32-bit cycle counter `cnt` is cleared on every state entry.
- **IDLE:**
  - btn_press → PRESS1.
  - btn_level is ignored here.
- **PRESS1:**
  - btn_level == 0 → GAP. Release has priority over long-press qualification on the same cycle.
  - Otherwise, if cnt == LONG_COUNT-1 → HELD and fire long_press.
  - Otherwise cnt++.
- **GAP:**
  - btn_press → PRESS2 and fire double_press. A press has priority over timeout on the same cycle.
  - Otherwise, if cnt == GAP_COUNT-1 → IDLE and fire short_press.
  - Otherwise cnt++.
- **PRESS2:**
  - btn_level == 0 → IDLE.
  - No long-press or repeat is generated in this state, however long the button is held.
- **HELD:**
  - btn_level == 0 → IDLE. Release generates no event.
  - Otherwise, if cnt == REPEAT_COUNT-1 → fire repeat_tick and clear cnt.
  - Otherwise cnt++.
- Event strobes are mutually exclusive, and each gesture produces exactly one of short_press, double_press or long_press.
- btn_press arriving in PRESS1, PRESS2 or HELD is ignored. It cannot occur with a correct debouncer.

## Timing
- Reset (rst_n low at a rising edge):
  - state = IDLE and cnt = 0.
  - All five outputs are 0 in the following cycle.
  - Reset mid-gesture discards the gesture without emitting any strobe.
- All outputs are registered. A strobe is high for exactly the one cycle following the edge at which its transition is taken.
- long_press is high LONG_COUNT cycles after the edge that sampled btn_press, provided btn_level stays high throughout.
- short_press is high GAP_COUNT cycles after the edge that first sampled btn_level low in PRESS1.
- double_press is high one cycle after the edge that sampled the second btn_press.
- The first repeat_tick comes REPEAT_COUNT cycles after the long_press cycle, then one every REPEAT_COUNT cycles until release.
- busy goes high the cycle after btn_press is sampled in IDLE, and low the cycle after the return to IDLE.
- The counter never wraps, because every state bounds it below its compare value.

## Structure
- Shared package `button_pkg`:
  - Enum typedef `gesture_state_t` for the five states.
  - A ms-to-cycles constant function used by both this block and the debouncer.
- Single module with no sub-module. The debouncer is instantiated alongside it at the top level, not inside it.

## Test plan
All scenarios use the bench parameters CLKFREQ=1000, LONG_PRESS_MS=8, DOUBLE_GAP_MS=4, REPEAT_MS=3, which give counts of 8, 4 and 3 cycles.

- **Short press:** btn_press at edge 0, level high for 3 cycles, low at edge 3 → short_press high only in the cycle after edge 7; no other strobes; busy low from the cycle after edge 7.
- **Double press:** press and release as above, second btn_press at edge 5 → double_press in the cycle after edge 5; hold the second press for 20 cycles → no long_press; release → IDLE.
- **Long press with repeat:** btn_press at edge 0, hold for 20 cycles:
  - long_press in the cycle after edge 8.
  - repeat_tick after edges 11, 14, 17.
  - Release at edge 20 → no further strobes.
- **Priority and boundary cases:**
  - Release sampled at the same edge where cnt == 7 in PRESS1 → GAP and an eventual short_press, with no long_press.
  - btn_press at the same edge as GAP timeout → double_press and no short_press.
- **Reset mid-operation:** rst_n low for one edge during GAP and during HELD → all outputs 0 the next cycle, no pending short_press, and a fresh btn_press is classified normally.

Source files
------------

// File: rtl/button_pkg.sv
// button_pkg: shared gesture-state encoding and ms-to-cycles conversion for the button front end.
package button_pkg;
  typedef enum logic [2:0] {IDLE, PRESS1, GAP, PRESS2, HELD} gesture_state_t;
  function automatic logic [31:0] ms_to_cycles(input int unsigned ms, input int unsigned clkfreq);
    return 32'(ms * (clkfreq / 1000));
  endfunction
endpackage

// File: rtl/button_gesture.sv
// button_gesture: classifies debounced button activity into short, double, long and repeat strobes.
module button_gesture
  import button_pkg::*;
#(
  parameter int unsigned CLKFREQ       = 100_000_000,
  parameter int unsigned LONG_PRESS_MS = 500,
  parameter int unsigned DOUBLE_GAP_MS = 250,
  parameter int unsigned REPEAT_MS     = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  input  logic btn_press,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_tick,
  output logic busy
);
  localparam logic [31:0] LONG_COUNT   = ms_to_cycles(LONG_PRESS_MS, CLKFREQ);
  localparam logic [31:0] GAP_COUNT    = ms_to_cycles(DOUBLE_GAP_MS, CLKFREQ);
  localparam logic [31:0] REPEAT_COUNT = ms_to_cycles(REPEAT_MS, CLKFREQ);
  gesture_state_t state, state_d;
  logic [31:0] cnt, cnt_d;
  logic short_d, double_d, long_d, repeat_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      repeat_tick  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      short_press  <= short_d;
      double_press <= double_d;
      long_press   <= long_d;
      repeat_tick  <= repeat_d;
      busy         <= state_d != IDLE;
    end
  end
  // Release beats long-press qualification; a second press beats the gap timeout.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt + 32'd1;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state)
      IDLE: begin
        cnt_d   = '0;
        state_d = btn_press ? PRESS1 : IDLE;
      end
      PRESS1:
        if (!btn_level) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (cnt == LONG_COUNT - 32'd1) begin
          state_d = HELD;
          cnt_d   = '0;
          long_d  = 1'b1;
        end
      GAP:
        if (btn_press) begin
          state_d  = PRESS2;
          cnt_d    = '0;
          double_d = 1'b1;
        end else if (cnt == GAP_COUNT - 32'd1) begin
          state_d = IDLE;
          cnt_d   = '0;
          short_d = 1'b1;
        end
      PRESS2: begin
        cnt_d   = '0;
        state_d = btn_level ? PRESS2 : IDLE;
      end
      HELD:
        if (!btn_level) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == REPEAT_COUNT - 32'd1) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_button_gesture.sv
// tb_button_gesture: directed scenarios with hand-computed per-cycle strobe masks.
module tb_button_gesture;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_level = 1'b0;
  logic btn_press = 1'b0;
  logic short_press, double_press, long_press, repeat_tick, busy;
  logic [63:0] sp_m, dp_m, lp_m, rt_m, by_m;
  int checks = 0;
  int errors = 0;

  button_gesture #(.CLKFREQ(1000), .LONG_PRESS_MS(8), .DOUBLE_GAP_MS(4), .REPEAT_MS(3)) dut (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .btn_press(btn_press),
    .short_press(short_press), .double_press(double_press), .long_press(long_press),
    .repeat_tick(repeat_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bit k of each mask holds the output in the cycle after edge k; inputs pr/lv/rs bit k are sampled at edge k.
  task automatic run(input int n, input logic [63:0] pr, input logic [63:0] lv, input logic [63:0] rs);
    sp_m = '0; dp_m = '0; lp_m = '0; rt_m = '0; by_m = '0;
    for (int k = 0; k < n; k++) begin
      btn_press = pr[k];
      btn_level = lv[k];
      rst_n = ~rs[k];
      @(posedge clk);
      @(negedge clk);
      sp_m[k] = short_press;
      dp_m[k] = double_press;
      lp_m[k] = long_press;
      rt_m[k] = repeat_tick;
      by_m[k] = busy;
    end
    btn_press = 1'b0;
    btn_level = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    run(3, 64'h1, 64'h7, 64'h7);
    checks++;
    if ({sp_m, dp_m, lp_m, rt_m, by_m} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got sp=%h dp=%h lp=%h rt=%h busy=%h required all 0", sp_m, dp_m, lp_m, rt_m, by_m);
    end
  endtask

  task automatic test_short(input string tag);
    run(12, 64'h1, 64'h7, 64'h0);
    checks++;
    if (sp_m !== 64'h80) begin errors++; $display("FAIL %s_short got %h required %h", tag, sp_m, 64'h80); end
    checks++;
    if ({dp_m, lp_m, rt_m} !== '0) begin errors++; $display("FAIL %s_others got dp=%h lp=%h rt=%h required 0", tag, dp_m, lp_m, rt_m); end
    checks++;
    if (by_m !== 64'h7f) begin errors++; $display("FAIL %s_busy got %h required %h", tag, by_m, 64'h7f); end
  endtask

  task automatic test_double();
    run(30, 64'h21, 64'h1ffffe7, 64'h0);
    checks++;
    if (dp_m !== 64'h20) begin errors++; $display("FAIL double_strobe got %h required %h", dp_m, 64'h20); end
    checks++;
    if ({sp_m, lp_m, rt_m} !== '0) begin errors++; $display("FAIL double_others got sp=%h lp=%h rt=%h required 0", sp_m, lp_m, rt_m); end
    checks++;
    if (by_m !== 64'h1ffffff) begin errors++; $display("FAIL double_busy got %h required %h", by_m, 64'h1ffffff); end
  endtask

  task automatic test_long_repeat();
    run(26, 64'h1, 64'hfffff, 64'h0);
    checks++;
    if (lp_m !== 64'h100) begin errors++; $display("FAIL long_strobe got %h required %h", lp_m, 64'h100); end
    checks++;
    if (rt_m !== 64'h24800) begin errors++; $display("FAIL long_repeat got %h required %h", rt_m, 64'h24800); end
    checks++;
    if ({sp_m, dp_m} !== '0) begin errors++; $display("FAIL long_others got sp=%h dp=%h required 0", sp_m, dp_m); end
    checks++;
    if (by_m !== 64'hfffff) begin errors++; $display("FAIL long_busy got %h required %h", by_m, 64'hfffff); end
  endtask

  task automatic test_priority();
    run(16, 64'h1, 64'hff, 64'h0);
    checks++;
    if (sp_m !== 64'h1000) begin errors++; $display("FAIL release_at_long_short got %h required %h", sp_m, 64'h1000); end
    checks++;
    if ({lp_m, dp_m, rt_m} !== '0) begin errors++; $display("FAIL release_at_long_others got lp=%h dp=%h rt=%h required 0", lp_m, dp_m, rt_m); end
    checks++;
    if (by_m !== 64'hfff) begin errors++; $display("FAIL release_at_long_busy got %h required %h", by_m, 64'hfff); end
    run(14, 64'h81, 64'h387, 64'h0);
    checks++;
    if (dp_m !== 64'h80) begin errors++; $display("FAIL press_at_timeout_double got %h required %h", dp_m, 64'h80); end
    checks++;
    if ({sp_m, lp_m, rt_m} !== '0) begin errors++; $display("FAIL press_at_timeout_others got sp=%h lp=%h rt=%h required 0", sp_m, lp_m, rt_m); end
    checks++;
    if (by_m !== 64'h3ff) begin errors++; $display("FAIL press_at_timeout_busy got %h required %h", by_m, 64'h3ff); end
  endtask

  task automatic test_reset_mid();
    run(12, 64'h1, 64'h7, 64'h20);
    checks++;
    if ({sp_m, dp_m, lp_m, rt_m} !== '0) begin errors++; $display("FAIL rst_gap_strobes got sp=%h dp=%h lp=%h rt=%h required 0", sp_m, dp_m, lp_m, rt_m); end
    checks++;
    if (by_m !== 64'h1f) begin errors++; $display("FAIL rst_gap_busy got %h required %h", by_m, 64'h1f); end
    test_short("after_rst_gap");
    run(18, 64'h1, 64'h7fff, 64'h1000);
    checks++;
    if (lp_m !== 64'h100) begin errors++; $display("FAIL rst_held_long got %h required %h", lp_m, 64'h100); end
    checks++;
    if (rt_m !== 64'h800) begin errors++; $display("FAIL rst_held_repeat got %h required %h", rt_m, 64'h800); end
    checks++;
    if ({sp_m, dp_m} !== '0) begin errors++; $display("FAIL rst_held_others got sp=%h dp=%h required 0", sp_m, dp_m); end
    checks++;
    if (by_m !== 64'hfff) begin errors++; $display("FAIL rst_held_busy got %h required %h", by_m, 64'hfff); end
    test_short("after_rst_held");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_short("short");
    test_double();
    test_long_repeat();
    test_priority();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
